// File: rtl/sfq_arb_pkg.sv
// Shared types and elaboration helpers for the SFQ merge arbiter family.
package sfq_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  function automatic int src_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic bit params_legal(input int n_req, input int gap);
    return (gap >= 1) && (n_req >= 2) && (n_req <= 16);
  endfunction

endpackage

// File: rtl/sfq_merge_arbiter_if.sv
// Request/grant bundle between requesters and the shared-line arbiter.
interface sfq_merge_arbiter_if #(
  parameter int N_REQ = 4
);
  import sfq_arb_pkg::*;

  localparam int SRC_W = src_w(N_REQ);

  logic             en;
  logic [N_REQ-1:0] req_pulse;
  logic             out_pulse;
  logic [SRC_W-1:0] out_src;
  logic [N_REQ-1:0] pend_nonzero;
  logic [N_REQ-1:0] drop_pulse;
  logic             busy;

  modport master (
    output en, req_pulse,
    input  out_pulse, out_src, pend_nonzero, drop_pulse, busy
  );

  modport slave (
    input  en, req_pulse,
    output out_pulse, out_src, pend_nonzero, drop_pulse, busy
  );

endinterface

// File: rtl/sfq_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after start, wrapping.
module sfq_rr_pick
  import sfq_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = src_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         valid,
  output logic [W-1:0] idx
);

  logic [2*N-1:0] dbl_s;
  logic [N-1:0]   rot_s;
  int             pos_s;

  // Rotate so that start lands on bit 0; scanning high-to-low leaves the nearest hit last
  always_comb begin
    dbl_s = {req, req} >> start;
    rot_s = dbl_s[N-1:0];
    valid = 1'b0;
    idx   = {W{1'b0}};
    pos_s = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        valid = 1'b1;
        pos_s = int'(start) + k;
        if (pos_s >= N) begin
          pos_s = pos_s - N;
        end else begin
          pos_s = pos_s;
        end
        idx = W'(pos_s);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/sfq_merge_arbiter.sv
// Queues SFQ request pulses per requester and re-emits them one at a time,
// round-robin, with a fixed minimum spacing onto the shared confluence line.
module sfq_merge_arbiter
  import sfq_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 3,
  parameter int GAP   = 3
) (
  input  logic               clkin,
  input  logic               rst,
  sfq_merge_arbiter_if.slave bus
);

  localparam int SRC_W = src_w(N_REQ);
  localparam int GAP_W = src_w(GAP);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SRC_W-1:0] SRC_ONE  = SRC_W'(1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  if (!params_legal(N_REQ, GAP)) begin : g_param_check
    $error("sfq_merge_arbiter: GAP must be >= 1 and N_REQ within 2..16");
  end

  arb_state_e       state_r, state_nxt_s;
  logic [GAP_W-1:0] gap_cnt_r, gap_cnt_nxt_s;
  logic [SRC_W-1:0] rr_ptr_r, rr_ptr_nxt_s;
  logic [CNT_W-1:0] cnt_r     [N_REQ];
  logic [CNT_W-1:0] cnt_nxt_s [N_REQ];
  logic [N_REQ-1:0] nz_s, dec_s, drop_nxt_s, pend_nxt_s;
  logic             pick_valid_s, grant_s;
  logic [SRC_W-1:0] pick_idx_s;
  logic             out_pulse_r, out_pulse_nxt_s;
  logic [SRC_W-1:0] out_src_r, out_src_nxt_s;
  logic [N_REQ-1:0] drop_r, pend_r;
  logic             busy_r;

  // Occupancy map of the registered counts; requests never bypass the counters
  always_comb begin
    nz_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      nz_s[i] = (cnt_r[i] != CNT_ZERO);
    end
  end

  sfq_rr_pick #(.N(N_REQ), .W(SRC_W)) u_pick (
    .req   (nz_s),
    .start (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign grant_s = (state_r == IDLE) && bus.en && pick_valid_s;

  // Per-requester counter update; a coincident request and grant cancel out
  always_comb begin
    dec_s      = {N_REQ{1'b0}};
    drop_nxt_s = {N_REQ{1'b0}};
    pend_nxt_s = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      dec_s[i]     = grant_s && (pick_idx_s == SRC_W'(i));
      if (bus.req_pulse[i] && !dec_s[i]) begin
        if (cnt_r[i] == CNT_MAX) begin
          drop_nxt_s[i] = 1'b1;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else if (!bus.req_pulse[i] && dec_s[i]) begin
        cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
      pend_nxt_s[i] = (cnt_nxt_s[i] != CNT_ZERO);
    end
  end

  // Grant / spacing FSM: next state and next registered outputs
  always_comb begin
    state_nxt_s     = state_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    rr_ptr_nxt_s    = rr_ptr_r;
    out_pulse_nxt_s = 1'b0;
    out_src_nxt_s   = out_src_r;
    case (state_r)
      IDLE: begin
        if (grant_s) begin
          out_pulse_nxt_s = 1'b1;
          out_src_nxt_s   = pick_idx_s;
          rr_ptr_nxt_s    = (pick_idx_s == LAST_IDX) ? {SRC_W{1'b0}} : (pick_idx_s + SRC_ONE);
          if (GAP > 1) begin
            gap_cnt_nxt_s = GAP_LOAD;
            state_nxt_s   = HOLD;
          end else begin
            state_nxt_s   = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        gap_cnt_nxt_s = gap_cnt_r - GAP_ONE;
        if (gap_cnt_r == GAP_ONE) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        gap_cnt_nxt_s = {GAP_W{1'b0}};
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clkin) begin
    if (rst) begin
      state_r   <= IDLE;
      gap_cnt_r <= {GAP_W{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      gap_cnt_r <= gap_cnt_nxt_s;
    end
  end

  // Counters, pointer and registered outputs
  always_ff @(posedge clkin) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
      rr_ptr_r    <= {SRC_W{1'b0}};
      out_pulse_r <= 1'b0;
      out_src_r   <= {SRC_W{1'b0}};
      drop_r      <= {N_REQ{1'b0}};
      pend_r      <= {N_REQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
      rr_ptr_r    <= rr_ptr_nxt_s;
      out_pulse_r <= out_pulse_nxt_s;
      out_src_r   <= out_src_nxt_s;
      drop_r      <= drop_nxt_s;
      pend_r      <= pend_nxt_s;
      busy_r      <= (state_nxt_s == HOLD) || (|pend_nxt_s);
    end
  end

  assign bus.out_pulse    = out_pulse_r;
  assign bus.out_src      = out_src_r;
  assign bus.drop_pulse   = drop_r;
  assign bus.pend_nonzero = pend_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_sfq_merge_arbiter.sv
// Directed bench for sfq_merge_arbiter: one GAP=3 and one GAP=1 instance share
// stimulus and are checked every cycle against a queue-and-timing model.
module tb_sfq_merge_arbiter;
  import sfq_arb_pkg::*;

  localparam int N = 4;
  localparam int CMAX = 7;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] req;

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance (0: GAP=3, 1: GAP=1)
  int           m_cnt [2][N];
  int           m_ptr [2];
  int           m_last[2];
  int           m_src [2];
  bit           m_pulse[2];
  bit [N-1:0]   m_drop[2];
  bit           m_busy[2];
  int           m_in  [2];
  int           m_out [2];
  int           m_drp [2];

  sfq_merge_arbiter_if #(.N_REQ(N)) if0 ();
  sfq_merge_arbiter_if #(.N_REQ(N)) if1 ();

  assign if0.en        = en;
  assign if0.req_pulse = req;
  assign if1.en        = en;
  assign if1.req_pulse = req;

  sfq_merge_arbiter #(.N_REQ(N), .CNT_W(3), .GAP(3)) dut0 (
    .clkin (clk),
    .rst   (rst),
    .bus   (if0.slave)
  );

  sfq_merge_arbiter #(.N_REQ(N), .CNT_W(3), .GAP(1)) dut1 (
    .clkin (clk),
    .rst   (rst),
    .bus   (if1.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One model edge: grant allowed once GAP edges have passed since the last grant
  task automatic model_step(input int d, input logic rv, input logic ev, input logic [N-1:0] qv, input int e);
    int win;
    int g;
    bit any;
    g = (d == 0) ? 3 : 1;
    if (rv) begin
      for (int i = 0; i < N; i++) m_cnt[d][i] = 0;
      m_ptr[d] = 0; m_last[d] = -1000; m_src[d] = 0;
      m_pulse[d] = 1'b0; m_drop[d] = '0;
      m_in[d] = 0; m_out[d] = 0; m_drp[d] = 0;
    end else begin
      win = -1;
      if (ev && (e - m_last[d] >= g)) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr[d] + k) % N;
          if (win < 0 && m_cnt[d][j] > 0) win = j;
        end
      end
      m_drop[d] = '0;
      for (int i = 0; i < N; i++) begin
        if (qv[i]) m_in[d]++;
        if (qv[i] && i != win) begin
          if (m_cnt[d][i] == CMAX) m_drop[d][i] = 1'b1;
          else m_cnt[d][i]++;
        end else if (!qv[i] && i == win) begin
          m_cnt[d][i]--;
        end
      end
      if (win >= 0) begin
        m_pulse[d] = 1'b1; m_src[d] = win; m_ptr[d] = (win + 1) % N; m_last[d] = e;
      end else begin
        m_pulse[d] = 1'b0;
      end
    end
    any = 1'b0;
    for (int i = 0; i < N; i++) if (m_cnt[d][i] > 0) any = 1'b1;
    m_busy[d] = ((e - m_last[d]) <= (g - 2)) || any;
  endtask

  // Per-cycle compare of both instances against the model
  initial begin : cmp_proc
    int e;
    bit started;
    logic rv, ev;
    logic [N-1:0] qv, a_drop, a_pend, x_pend;
    logic a_pulse, a_busy;
    logic [1:0] a_src;
    int sum;
    e = 0;
    started = 1'b0;
    forever begin
      @(posedge clk);
      rv = rst; ev = en; qv = req;
      e++;
      for (int d = 0; d < 2; d++) model_step(d, rv, ev, qv, e);
      if (rv) started = 1'b1;
      #1;
      if (started) begin
        for (int d = 0; d < 2; d++) begin
          if (d == 0) begin
            a_pulse = if0.out_pulse; a_src = if0.out_src; a_drop = if0.drop_pulse;
            a_pend = if0.pend_nonzero; a_busy = if0.busy;
          end else begin
            a_pulse = if1.out_pulse; a_src = if1.out_src; a_drop = if1.drop_pulse;
            a_pend = if1.pend_nonzero; a_busy = if1.busy;
          end
          sum = 0;
          for (int i = 0; i < N; i++) begin
            x_pend[i] = (m_cnt[d][i] > 0);
            sum += m_cnt[d][i];
          end
          chk($sformatf("d%0d_out_pulse@%0d", d, e), a_pulse, m_pulse[d]);
          chk($sformatf("d%0d_out_src@%0d", d, e), a_src, m_src[d]);
          chk($sformatf("d%0d_drop@%0d", d, e), a_drop, m_drop[d]);
          chk($sformatf("d%0d_pend@%0d", d, e), a_pend, x_pend);
          chk($sformatf("d%0d_busy@%0d", d, e), a_busy, m_busy[d]);
          m_out[d] += a_pulse;
          m_drp[d] += $countones(a_drop);
          chk($sformatf("d%0d_conserve@%0d", d, e), m_in[d], m_out[d] + m_drp[d] + sum);
        end
      end
    end
  end

  // Apply inputs on the falling edge; return just after the rising edge that sampled them
  task automatic cyc(input logic r, input logic e, input logic [N-1:0] q);
    @(negedge clk);
    rst = r; en = e; req = q;
    @(posedge clk);
    #2;
  endtask

  initial begin : stim
    int n;
    rst = 1'b1; en = 1'b0; req = '0;

    // reset state
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 4'b0000);
    chk("rst_out_pulse", if0.out_pulse, 1'b0);
    chk("rst_out_src", if0.out_src, 2'd0);
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_pend", if0.pend_nonzero, 4'b0000);

    // single request, one-cycle latency then two HOLD cycles
    cyc(1'b0, 1'b1, 4'b0100);
    chk("t1_pend", if0.pend_nonzero, 4'b0100);
    chk("t1_nopulse", if0.out_pulse, 1'b0);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t1_pulse", if0.out_pulse, 1'b1);
    chk("t1_src", if0.out_src, 2'd2);
    chk("t1_pend0", if0.pend_nonzero, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t1_busy_hold", if0.busy, 1'b1);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t1_busy_done", if0.busy, 1'b0);

    // all four at once: 3-cycle spacing, order 0,1,2,3
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b1111);
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      chk($sformatf("t2_pulse_k%0d", k), if0.out_pulse, (k % 3 == 0));
      if (k % 3 == 0) chk($sformatf("t2_src_k%0d", k), if0.out_src, k / 3);
      chk($sformatf("t2_busy_k%0d", k), if0.busy, (k <= 10));
    end

    // saturation while disabled, then drain
    cyc(1'b1, 1'b0, 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 1'b0, 4'b0010);
      chk($sformatf("t3_drop_k%0d", k), if0.drop_pulse, (k >= 8) ? 4'b0010 : 4'b0000);
    end
    n = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      if (if0.out_pulse && if0.out_src == 2'd1) n++;
    end
    chk("t3_drain_count", n, 7);
    chk("t3_pend_empty", if0.pend_nonzero, 4'b0000);

    // request coinciding with grant at count 2
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b1, 4'b1000);
    chk("t4a_pulse", if0.out_pulse, 1'b1);
    chk("t4a_src", if0.out_src, 2'd3);
    chk("t4a_drop", if0.drop_pulse, 4'b0000);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      if (if0.out_pulse) n++;
    end
    chk("t4a_drain_count", n, 2);

    // same coincidence at saturation
    cyc(1'b1, 1'b0, 4'b0000);
    for (int k = 0; k < 7; k++) cyc(1'b0, 1'b0, 4'b1000);
    cyc(1'b0, 1'b1, 4'b1000);
    chk("t4b_pulse", if0.out_pulse, 1'b1);
    chk("t4b_drop", if0.drop_pulse, 4'b0000);
    n = 0;
    for (int k = 0; k < 24; k++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      if (if0.out_pulse) n++;
    end
    chk("t4b_drain_count", n, 7);

    // reset during HOLD discards everything
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 4'b1011);
    cyc(1'b0, 1'b0, 4'b1010);
    cyc(1'b0, 1'b0, 4'b1000);
    chk("t5_pend", if0.pend_nonzero, 4'b1011);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t5_grant_src", if0.out_src, 2'd0);
    chk("t5_busy", if0.busy, 1'b1);
    cyc(1'b1, 1'b1, 4'b0000);
    chk("t5_rst_pend", if0.pend_nonzero, 4'b0000);
    chk("t5_rst_busy", if0.busy, 1'b0);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t5_no_pulse", if0.out_pulse, 1'b0);
    cyc(1'b0, 1'b1, 4'b0010);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t5_new_pulse", if0.out_pulse, 1'b1);
    chk("t5_new_src", if0.out_src, 2'd1);

    // GAP=1 instance: back-to-back alternating grants
    cyc(1'b1, 1'b0, 4'b0000);
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 4'b0101);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b1, 4'b0000);
      chk($sformatf("t6_pulse_k%0d", k), if1.out_pulse, 1'b1);
      chk($sformatf("t6_src_k%0d", k), if1.out_src, (k % 2 == 0) ? 2'd0 : 2'd2);
    end
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t6_pulse_end", if1.out_pulse, 1'b0);
    chk("t6_busy_end", if1.busy, 1'b0);

    // en dropped during HOLD: HOLD finishes, then wait for en
    cyc(1'b1, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 4'b0011);
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t7_first_src", if0.out_src, 2'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 4'b0000);
      chk($sformatf("t7_idle_k%0d", k), if0.out_pulse, 1'b0);
    end
    cyc(1'b0, 1'b1, 4'b0000);
    chk("t7_resume_pulse", if0.out_pulse, 1'b1);
    chk("t7_resume_src", if0.out_src, 2'd1);

    cyc(1'b0, 1'b1, 4'b0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
